// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared states, default parameters and settle clamp for the SAR ADC sequencer
package sar_adc_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEFAULT_SETTLE_DEF = 4;
  localparam logic [7:0] SETTLE_MIN = 8'(SYNC_STAGES_DEF + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;
  // Settle count never drops below the synchronizer depth plus one, so the
  // sampled comparator always reflects the current trial code.
  function automatic logic [7:0] clamp_settle(input logic [7:0] d, input logic [7:0] min_s);
    return d < min_s ? min_s : d;
  endfunction
endpackage

// File: rtl/sar_adc_control_cmp_sync.sv
// cmp_sync: flop-chain synchronizer for asynchronous analog flags
module cmp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  // shift the asynchronous flag through the chain, oldest at the top
  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/sar_adc_control.sv
// sar_adc_control: successive-approximation sequencer driving the R2R DAC as reference ladder
module sar_adc_control
  import sar_adc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEFAULT_SETTLE = DEFAULT_SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             cmp_in,
  input  logic             load_settle,
  input  logic [7:0]       settle_data,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
  localparam logic [7:0] SMIN = 8'(SYNC_STAGES + 1);
  state_t state;
  logic [IW-1:0] bit_idx;
  logic [7:0] cnt;
  logic [7:0] settle_reg;
  logic [7:0] settle_cur;
  logic cmp_s;
  logic [WIDTH-1:0] keep;
  logic [WIDTH-1:0] nxt;
  cmp_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(cmp_in),
    .q(cmp_s)
  );
  // trial code after this bit's decision: drop the bit if the input is below, arm the next one
  always_comb begin
    keep = cmp_s ? dac_code : dac_code & ~(ONE << bit_idx);
    nxt = bit_idx != '0 ? keep | (ONE << (bit_idx - 1'b1)) : keep;
  end
  // conversion sequencer; settle_cur freezes the settle count for the running conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dac_code <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      bit_idx <= '0;
      cnt <= '0;
      settle_reg <= 8'(DEFAULT_SETTLE);
      settle_cur <= 8'(DEFAULT_SETTLE);
    end else begin
      done <= 1'b0;
      if (state == IDLE && load_settle) settle_reg <= clamp_settle(settle_data, SMIN);
      case (state)
        IDLE: if (start) begin
          state <= SETTLE;
          busy <= 1'b1;
          bit_idx <= IW'(WIDTH - 1);
          dac_code <= MSB;
          cnt <= '0;
          settle_cur <= settle_reg;
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (cnt == settle_cur - 8'd1) state <= DECIDE;
        end
        DECIDE: begin
          dac_code <= nxt;
          cnt <= '0;
          if (bit_idx != '0) begin
            bit_idx <= bit_idx - 1'b1;
            state <= SETTLE;
          end else state <= DONE;
        end
        DONE: begin
          result <= dac_code;
          done <= 1'b1;
          cnt <= '0;
          bit_idx <= IW'(WIDTH - 1);
          settle_cur <= settle_reg;
          state <= continuous ? SETTLE : IDLE;
          busy <= continuous;
          dac_code <= continuous ? MSB : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sar_adc_control.sv
// tb_sar_adc_control: vector table plus scoreboard of expected done edges and results
module tb_sar_adc_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic cmp_in = 1'b0;
  logic load_settle = 1'b0;
  logic [7:0] settle_data = 8'd0;
  logic [7:0] dac_code;
  logic busy;
  logic done;
  logic [7:0] result;
  sar_adc_control dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .continuous(continuous),
    .cmp_in(cmp_in),
    .load_settle(load_settle),
    .settle_data(settle_data),
    .dac_code(dac_code),
    .busy(busy),
    .done(done),
    .result(result)
  );
  always #50 clk = ~clk;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] vin = 8'd0;
  logic cmp_d = 1'b0;
  logic cur_c;
  typedef struct {logic [7:0] res; int at;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] trace[$];
  logic [7:0] last_code = 8'd0;
  typedef struct {logic [7:0] vin; logic load; logic [7:0] sdata; int s; logic [7:0] want;} vec_t;
  vec_t vecs[7];
  logic [7:0] a5_trace[8];
  int t0;
  task automatic check(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  // comparator model: vin >= dac_code, randomly presented 0 or 1 cycle late
  always @(negedge clk) begin
    cur_c = vin >= dac_code;
    cmp_in = ($urandom_range(1) == 1) ? cmp_d : cur_c;
    cmp_d = cur_c;
  end
  // records trial codes and checks each done pulse against the scoreboard
  always @(negedge clk) begin
    if (busy && dac_code != last_code) trace.push_back(dac_code);
    last_code = dac_code;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got pulse at edge %0d expected none", edge_n);
      end else begin
        mon_e = sb.pop_front();
        check("done_edge", edge_n, mon_e.at);
        check("result", result, mon_e.res);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_conv(input logic [7:0] v, input int s, input logic [7:0] want);
    vin = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sb.push_back('{want, edge_n + 8 * (s + 1) + 1});
    check("start_busy", busy, 1);
    check("start_code", dac_code, 8'h80);
  endtask
  task automatic wait_sb(input int left, input int budget);
    int k = 0;
    while (sb.size() > left && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() > left) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d results pending expected %0d", sb.size(), left);
      while (sb.size() > left) void'(sb.pop_front());
    end
  endtask
  initial begin
    vecs[0] = '{8'hA5, 1'b0, 8'd0, 4, 8'hA5};
    vecs[1] = '{8'h00, 1'b0, 8'd0, 4, 8'h00};
    vecs[2] = '{8'hFF, 1'b0, 8'd0, 4, 8'hFF};
    vecs[3] = '{8'h5A, 1'b1, 8'd1, 3, 8'h5A};
    vecs[4] = '{8'h3C, 1'b1, 8'd7, 7, 8'h3C};
    vecs[5] = '{8'h81, 1'b1, 8'd0, 3, 8'h81};
    vecs[6] = '{8'h01, 1'b1, 8'd4, 4, 8'h01};
    a5_trace = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    tick(3);
    check("rst_code", dac_code, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    tick(1);
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].load) begin
        load_settle = 1'b1;
        settle_data = vecs[i].sdata;
        tick(1);
        load_settle = 1'b0;
      end
      trace.delete();
      start_conv(vecs[i].vin, vecs[i].s, vecs[i].want);
      wait_sb(0, 600);
      tick(1);
      check("idle_busy", busy, 0);
      check("idle_code", dac_code, 0);
      if (i == 0) begin
        check("trace_len", trace.size(), 8);
        for (int j = 0; j < 8 && j < trace.size(); j++) check("trace_code", trace[j], a5_trace[j]);
      end
    end
    start_conv(8'h33, 4, 8'h33);
    tick(10);
    start = 1'b1;
    load_settle = 1'b1;
    settle_data = 8'd9;
    tick(1);
    start = 1'b0;
    load_settle = 1'b0;
    wait_sb(0, 600);
    tick(1);
    start_conv(8'hC3, 4, 8'hC3);
    wait_sb(0, 600);
    tick(1);
    check("after_mid_busy", busy, 0);
    continuous = 1'b1;
    start_conv(8'h10, 4, 8'h10);
    sb.push_back('{8'hEF, sb[0].at + 41});
    wait_sb(1, 600);
    vin = 8'hEF;
    check("cont_busy", busy, 1);
    tick(10);
    continuous = 1'b0;
    wait_sb(0, 600);
    tick(50);
    check("cont_stop_busy", busy, 0);
    check("cont_result", result, 8'hEF);
    vin = 8'h5A;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t0 = edge_n;
    tick(19);
    check("mid_result_held", result, 8'hEF);
    rst = 1'b1;
    tick(1);
    check("mid_rst_edge", edge_n, t0 + 20);
    check("mid_rst_code", dac_code, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    tick(60);
    check("post_rst_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sar_adc_control.md
# sar_adc_control

Successive-approximation ADC sequencer that reuses the 8-bit R2R DAC as the reference ladder, making the DAC macro usable as an input path. It drives trial codes through the 1v8 `dac_drive` level shifters, samples an analog comparator (analog input vs. R2R output) and assembles the conversion result bit by bit, MSB first. It sits in the 1v8 digital domain beside `r2r_dac_control`. The top-level mux selects which of the two blocks owns `r2r_out`.

## Interface
- `WIDTH`, 8: conversion width; equals the DAC width.
- `SYNC_STAGES`, 2: flops in the comparator synchronizer.
- `DEFAULT_SETTLE`, 4: settle cycles per bit after reset.
- `clk` input 1: single clock, 10 MHz nominal.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a conversion; sampled only in IDLE.
- `continuous` input 1: when high, a new conversion starts automatically after DONE.
- `cmp_in` input 1: asynchronous comparator output; 1 = analog input ≥ DAC output.
- `load_settle` input 1: load `settle_data` into the settle register; honoured only in IDLE.
- `settle_data` input 8: new settle count.
- `dac_code` output WIDTH: trial code to the `dac_drive` inputs.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when `result` updates.
- `result` output WIDTH: last completed conversion; held until the next `done`.

## Operation
- States:
  - IDLE: `dac_code`=0.
  - SETTLE: count settle cycles with the trial code applied.
  - DECIDE: one cycle; evaluate `cmp_sync`.
  - DONE: one cycle; `done`=1.
- IDLE→SETTLE on `start`=1. Load `bit_idx`=WIDTH-1, `dac_code`=1<<(WIDTH-1), and clear the settle counter.
- SETTLE→DECIDE when the counter reaches `settle_reg`-1.
- DECIDE actions:
  - If `cmp_sync`=0, clear `dac_code[bit_idx]`; otherwise keep it.
  - If `bit_idx`>0, set `dac_code[bit_idx-1]`, decrement `bit_idx`, and return to SETTLE.
  - If `bit_idx`=0, go to DONE.
- DONE: `result` ← final `dac_code` and `done`=1. Then go to SETTLE (new conversion) if `continuous`=1, otherwise to IDLE with `dac_code` cleared.
- `cmp_sync` is `cmp_in` passed through SYNC_STAGES flops. The flops reset to 0.
- `settle_reg` (8 bit) resets to DEFAULT_SETTLE.
  - On `load_settle` in IDLE it loads `settle_data` clamped to a minimum of SYNC_STAGES+1. This guarantees the synchronizer reflects the current trial code.
  - `load_settle` outside IDLE is ignored. A `settle_reg` change takes effect at the next `start`.
- `start` while `busy` is ignored; it is not queued.
- `start` and `load_settle` in the same IDLE cycle: both take effect. The conversion uses the old `settle_reg`, and the new value applies from the next conversion.
- Reset at any point returns all outputs to reset values within one edge. An in-flight conversion is discarded and `result` is not updated.

## Timing
- Reset values: `dac_code`=0, `busy`=0, `done`=0, `result`=0, state=IDLE.
- `start` high at edge 0: `busy`=1 and `dac_code`=0x80 from edge 0 onward.
- Each bit takes S+1 cycles (S = `settle_reg`).
- `done` is high for exactly the cycle after edge WIDTH·(S+1)+1. That is edge 41 for S=4, WIDTH=8.
- `result` is valid from the same edge and stable until the next `done`.
- Continuous mode: consecutive `done` pulses are WIDTH·(S+1)+1 cycles apart.
- `dac_code` changes only on DECIDE→SETTLE, DONE and IDLE-entry edges. The code is glitch-free to the level shifters.

## Structure
- `sar_adc_pkg` holds:
  - the state enum (IDLE, SETTLE, DECIDE, DONE);
  - WIDTH, SYNC_STAGES and DEFAULT_SETTLE defaults;
  - the settle-clamp minimum constant.
- Sub-module `cmp_sync`: parameterised SYNC_STAGES flop chain with synchronous active-high reset. It is reusable for other asynchronous analog flags.
- The top level muxes `dac_code` against `r2r_dac_control`'s `r2r_out`. That mux is outside this block.

## Test plan
All scenarios use a bench comparator model: `cmp_in` = (`vin_code` ≥ `dac_code`), delayed 0–1 cycle at random.
- Reset, then `start` with `vin_code`=0xA5, S=4 → `dac_code` trace 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5. `done` on cycle 41, `result`=0xA5.
- Edge codes: `vin_code`=0x00 → `result`=0x00, and `vin_code`=0xFF → `result`=0xFF. `done` is a single cycle each time.
- `load_settle` with `settle_data`=1 in IDLE → `settle_reg`=3 (clamped). Next conversion: `done` on cycle 8·4+1=33, `result` correct.
- `start` and `load_settle` pulsed mid-conversion → no restart, `settle_reg` unchanged, `done` on the original cycle.
- `continuous`=1, `vin_code` changed 0x10→0xEF between conversions → `done` pulses every 41 cycles with `result` 0x10 then 0xEF. Dropping `continuous` returns to IDLE after the current DONE.
- `rst` asserted on cycle 20 of a conversion → next cycle `dac_code`=0, `busy`=0, `result`=0, no `done` pulse.
